// File: rtl/pipelined_barrel_shifter_pkg.sv
// shifter_pkg: operation encoding and width helper shared by the barrel shifter files
package shifter_pkg;
  typedef enum logic [1:0] {
    SHIFT_SRL = 2'd0,
    SHIFT_SRA = 2'd1,
    SHIFT_SLL = 2'd2,
    SHIFT_ROR = 2'd3
  } shift_op_e;
  function automatic int clog2w(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/pipelined_barrel_shifter_stage.sv
// shift_stage: one 2^STAGE level of the barrel shifter plus its pipeline registers (tag carried when SHIFT_TAG_EN)
module shift_stage import shifter_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int STAGE = 0
`ifdef SHIFT_TAG_EN
  , parameter int TAG_W = 4
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [clog2w(WIDTH)-1:0]  in_shamt,
  input  shift_op_e                 in_op,
`ifdef SHIFT_TAG_EN
  input  logic [TAG_W-1:0]          in_tag,
  output logic [TAG_W-1:0]          out_tag,
`endif
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [clog2w(WIDTH)-1:0]  out_shamt,
  output shift_op_e                 out_op
);
  localparam int S = 1 << STAGE;
  logic [WIDTH-1:0] shifted;
  // this level's mux: shift by S when its own shamt bit is set, otherwise pass through
  always_comb begin
    shifted = !in_shamt[STAGE]   ? in_data :
              in_op == SHIFT_SRL ? in_data >> S :
              in_op == SHIFT_SRA ? {{S{in_data[WIDTH-1]}}, in_data[WIDTH-1:S]} :
              in_op == SHIFT_SLL ? in_data << S :
                                   {in_data[S-1:0], in_data[WIDTH-1:S]};
  end
  // stage registers advance together under the global enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_shamt <= '0;
      out_op    <= SHIFT_SRL;
`ifdef SHIFT_TAG_EN
      out_tag   <= '0;
`endif
    end else if (en) begin
      out_valid <= in_valid;
      out_data  <= shifted;
      out_shamt <= in_shamt;
      out_op    <= in_op;
`ifdef SHIFT_TAG_EN
      out_tag   <= in_tag;
`endif
    end
  end
endmodule

// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter: log2(WIDTH)-stage SRL/SRA/SLL/ROR shifter with global-stall handshake; SHIFT_TAG_EN adds a sideband tag
module pipelined_barrel_shifter import shifter_pkg::*; #(
  parameter int WIDTH = 32
`ifdef SHIFT_TAG_EN
  , parameter int TAG_W = 4
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [clog2w(WIDTH)-1:0]  in_shamt,
  input  logic [1:0]                in_op,
`ifdef SHIFT_TAG_EN
  input  logic [TAG_W-1:0]          in_tag,
  output logic [TAG_W-1:0]          out_tag,
`endif
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      busy,
  output logic [clog2w(WIDTH):0]    inflight
);
  localparam int SHAMT_W = clog2w(WIDTH);
  logic               v [SHAMT_W+1];
  logic [WIDTH-1:0]   d [SHAMT_W+1];
  logic [SHAMT_W-1:0] s [SHAMT_W+1];
  shift_op_e          o [SHAMT_W+1];
`ifdef SHIFT_TAG_EN
  logic [TAG_W-1:0]   t [SHAMT_W+1];
  assign t[0]    = in_tag;
  assign out_tag = t[SHAMT_W];
`endif
  logic adv, acc, hs;
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;
  assign acc       = in_valid & adv;
  assign hs        = out_valid & out_ready;
  assign v[0]      = in_valid;
  assign d[0]      = in_data;
  assign s[0]      = in_shamt;
  assign o[0]      = shift_op_e'(in_op);
  assign out_valid = v[SHAMT_W];
  assign out_data  = d[SHAMT_W];
  assign busy      = inflight != '0;
  for (genvar g = 0; g < SHAMT_W; g++) begin : g_stage
    shift_stage #(
      .WIDTH(WIDTH),
      .STAGE(g)
`ifdef SHIFT_TAG_EN
      , .TAG_W(TAG_W)
`endif
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (adv),
      .in_valid (v[g]),
      .in_data  (d[g]),
      .in_shamt (s[g]),
      .in_op    (o[g]),
`ifdef SHIFT_TAG_EN
      .in_tag   (t[g]),
      .out_tag  (t[g+1]),
`endif
      .out_valid(v[g+1]),
      .out_data (d[g+1]),
      .out_shamt(s[g+1]),
      .out_op   (o[g+1])
    );
  end
  // occupancy tracks accepts minus output handshakes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight <= '0;
    else if (acc & ~hs) inflight <= inflight + 1'b1;
    else if (hs & ~acc) inflight <= inflight - 1'b1;
  end
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb_pipelined_barrel_shifter: directed and randomized checks against a queue-based reference model
module tb_pipelined_barrel_shifter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [4:0]  in_shamt = '0;
  logic [1:0]  in_op = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        busy;
  logic [5:0]  inflight;
`ifdef SHIFT_TAG_EN
  logic [3:0]  in_tag = '0;
  logic [3:0]  out_tag;
  logic [3:0]  tag_q[$];
`endif
  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] cur_exp;
  int model_cnt = 0;
  logic held = 1'b0;
  logic [31:0] held_data;
  logic acc, hs;

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_shamt (in_shamt),
    .in_op    (in_op),
`ifdef SHIFT_TAG_EN
    .in_tag   (in_tag),
    .out_tag  (out_tag),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy),
    .inflight (inflight)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] dv, input int n);
    logic signed [31:0] sd = dv;
    logic [63:0] dd = {dv, dv};
    case (op)
      2'd0: return dv >> n;
      2'd1: return sd >>> n;
      2'd2: return dv << n;
      default: return dd[31:0] >> 0 == 0 ? 32'(dd >> n) : 32'(dd >> n);
    endcase
  endfunction

  task automatic cycle();
    @(negedge clk);
    chk("rdy", in_ready, !out_valid | out_ready);
    chk("inflight", inflight, model_cnt);
    chk("busy", busy, model_cnt != 0);
    if (held) chk("hold_data", out_data, held_data);
    acc = in_valid & in_ready;
    hs = out_valid & out_ready;
    if (hs) begin
      if (exp_q.size() == 0) chk("spurious", out_valid, 0);
      else begin
        chk("data", out_data, exp_q.pop_front());
`ifdef SHIFT_TAG_EN
        chk("tag", out_tag, tag_q.pop_front());
`endif
      end
    end
    if (acc) begin
      exp_q.push_back(cur_exp);
`ifdef SHIFT_TAG_EN
      tag_q.push_back(in_tag);
`endif
    end
    model_cnt += int'(acc) - int'(hs);
    held = out_valid & !out_ready;
    held_data = out_data;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] dv, input logic [4:0] sh, input logic [31:0] ex);
    int n = 0;
    in_valid = 1'b1; in_op = op; in_data = dv; in_shamt = sh; cur_exp = ex;
    acc = 1'b0;
    while (!acc && n < 50) begin
      cycle();
      n++;
    end
    if (!acc) chk("send_timeout", in_ready, 1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 60) begin
      cycle();
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    int lat, i, hold, peak;
    logic seen;
    #3;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_infl", inflight, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", in_ready, 1);

    send(2'd0, 32'h8000_0001, 5'd1, 32'h4000_0000);
    lat = 1;
    while (!out_valid && lat < 20) begin
      cycle();
      lat++;
    end
    chk("latency", lat, 5);
    drain();

    send(2'd1, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
    send(2'd1, 32'h4000_0000, 5'd30, 32'h0000_0001);
    send(2'd2, 32'h0000_0001, 5'd31, 32'h8000_0000);
    send(2'd3, 32'h0000_0001, 5'd1,  32'h8000_0000);
    for (int k = 0; k < 4; k++) send(2'(k), 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF);
    send(2'd3, 32'h0000_00F0, 5'd4, 32'h0000_000F);
    send(2'd1, 32'h7FFF_0000, 5'd16, 32'h0000_7FFF);
    drain();

    i = 0; hold = 0; peak = 0; seen = 1'b0;
    for (int c = 0; c < 80 && (i < 8 || exp_q.size() != 0); c++) begin
      in_valid = i < 8; in_op = 2'd3; in_data = 32'(i); in_shamt = 5'(i);
      cur_exp = ref_shift(2'd3, 32'(i), i);
      if (!seen && out_valid) begin seen = 1'b1; hold = 3; end
      out_ready = hold == 0;
      cycle();
      if (acc) i++;
      if (hold > 0) hold--;
      if (int'(inflight) > peak) peak = int'(inflight);
    end
    in_valid = 1'b0;
    chk("stall_sent", i, 8);
    chk("stall_peak", peak, 5);
    chk("stall_end_infl", inflight, 0);

    for (int k = 0; k < 3; k++) send(2'd2, $urandom, 5'($urandom_range(0, 31)), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_infl", inflight, 0);
    chk("mid_rst_busy", busy, 0);
    exp_q.delete();
`ifdef SHIFT_TAG_EN
    tag_q.delete();
`endif
    model_cnt = 0; held = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (10) cycle();

`ifdef SHIFT_TAG_EN
    for (int k = 1; k <= 5; k++) begin
      in_tag = 4'(k);
      send(2'd0, 32'(k * 256), 5'(k), 32'(k * 256) >> k);
    end
    drain();
`endif

    for (int c = 0; c < 500; c++) begin
      in_valid = $urandom_range(0, 9) < 7;
      in_op = 2'($urandom_range(0, 3));
      in_data = $urandom;
      in_shamt = 5'($urandom_range(0, 31));
`ifdef SHIFT_TAG_EN
      in_tag = 4'($urandom_range(0, 15));
`endif
      out_ready = $urandom_range(0, 9) < 7;
      cur_exp = ref_shift(in_op, in_data, int'(in_shamt));
      cycle();
    end
    drain();
    chk("final_infl", inflight, 0);
    chk("final_busy", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, fully pipelined barrel shifter with one register stage per shift-amount bit, so it accepts one operation per cycle.
Supports logical right, arithmetic right, logical left and rotate right, selected per operation.
Uses valid/ready handshakes on input and output with back-pressure (global stall).
Serves as the shift unit for datapath and ALU blocks. WIDTH=32 gives a 5-stage unit.

Parameters:
WIDTH, 32, data width; must be a power of two and at least 2.
SHAMT_W, $clog2(WIDTH), shift-amount width and number of pipeline stages; derived localparam, not overridable.
TAG_W, 4, sideband tag width; used only when SHIFT_TAG_EN is defined.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst_n  input  1  reset, asynchronous assert, active-low.
in_valid  input  1  input operation valid.
in_ready  output  1  shifter can accept an operation this cycle.
in_data  input  WIDTH  operand.
in_shamt  input  SHAMT_W  shift amount, 0..WIDTH-1.
in_op  input  2  operation: 0 SRL, 1 SRA, 2 SLL, 3 ROR.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts the result.
out_data  output  WIDTH  result.
busy  output  1  at least one operation is in flight or held at the output.
inflight  output  SHAMT_W+1  count of valid stage entries, 0..SHAMT_W.

Behaviour:
- Reset (rst_n=0, asynchronous): every stage valid bit, data, shamt, op and tag register clears to 0; out_valid=0, out_data=0, inflight=0, busy=0. in_ready=1 from the first cycle after reset. Operations in flight when reset asserts are discarded and never appear at the output.
- Advance: adv = ~out_valid | out_ready. When adv=1, every stage loads from the previous stage in the same cycle. When adv=0, every stage holds its contents.
- Input side: in_ready = adv. An operation is accepted when in_valid & in_ready. When adv=1 and in_valid=0, a bubble (valid=0) enters stage 0.
- Bubbles are not collapsed. The pipeline is a rigid shift of SHAMT_W slots.
- Stage k (k=0..SHAMT_W-1) applies a shift of 2^k when the pipelined shamt bit k is 1, otherwise passes the data through. shamt and op travel with the data, and each stage uses only its own delayed copy.
- Fill value for vacated bits:
  - SRL and SLL fill with 0.
  - SRA fills with the sign bit of the original operand, i.e. the MSB of the stage input. Stage-by-stage sign extension is equivalent.
  - ROR wraps the low bits into the MSBs.
- Latency: exactly SHAMT_W cycles from acceptance to out_valid when there is no stall. out_valid and out_data come directly from the final stage registers. Throughput is 1 per cycle while out_ready=1.
- shamt=0 returns in_data unchanged for all ops.
- Results leave in acceptance order. None are lost or duplicated under any out_ready pattern.
- While out_valid=1 and out_ready=0, out_data stays stable and the whole pipeline freezes.
- inflight:
  - +1 when an accept occurs without an output handshake.
  - -1 when an output handshake (out_valid & out_ready) occurs without an accept.
  - Unchanged when both or neither occur.
- busy = (inflight != 0).

Optional Feature:
SHIFT_TAG_EN
- Defined: adds ports in_tag (input, TAG_W) and out_tag (output, TAG_W). The tag is pipelined alongside the data, emerges with its result, resets to 0, and holds during stalls.
- Undefined: the ports and registers do not exist, and behaviour is otherwise identical.

Decomposition:
- Package shifter_pkg holds:
  - typedef shift_op_e, with constants SHIFT_SRL=0, SHIFT_SRA=1, SHIFT_SLL=2, SHIFT_ROR=3;
  - a function returning $clog2 for the derived widths.
- Sub-module shift_stage, parameterised by WIDTH and STAGE. It contains one level of the mux network plus its valid/data/shamt/op(/tag) registers with an enable input. The top module instantiates SHAMT_W of them in a generate loop and holds the handshake and inflight logic.

Test Plan:
- WIDTH=32, SRL 0x8000_0001 shamt 1 -> out_data 0x4000_0000, out_valid asserts exactly 5 cycles after accept.
- SRA 0x8000_0000 shamt 31 -> 0xFFFF_FFFF. SRA 0x4000_0000 shamt 30 -> 0x0000_0001.
- SLL 0x0000_0001 shamt 31 -> 0x8000_0000. ROR 0x0000_0001 shamt 1 -> 0x8000_0000. Any op with shamt 0 on 0xDEAD_BEEF -> 0xDEAD_BEEF.
- Back-to-back stall: 8 consecutive ROR ops (data i, shamt i), with out_ready held low for 3 cycles once the first result appears -> in_ready=0 during the hold, out_data stable, all 8 results in order, inflight peaks at 5 and ends at 0.
- Reset mid-flight: accept 3 ops, assert rst_n=0 for 1 cycle -> out_valid=0, out_data=0, inflight=0 immediately, none of the 3 results ever appear, in_ready=1 after release.
- With SHIFT_TAG_EN defined, tags 0x1..0x5 on consecutive ops -> out_tag sequence 0x1..0x5 aligned with the matching results.
